i2c_slave_mem: RTL
==================

# i2c_slave_mem

Parametrised I2C target with an internal byte-wide register file, a programmable 7-bit device address, a register pointer and burst auto-increment. It oversamples SCL/SDA on the system clock with proper START/STOP edge detection instead of fixed per-bit timing, so it tracks any SCL rate up to clk/16. It ACKs only its own address. It sits on the shared open-drain bus next to the I2C master and is the next generation of the single-byte, fixed-timing slave.

## Interface
- SLAVE_ADDR, 7'h50, 7-bit device address matched after START
- ADDR_W, 7, register-file address width; depth = 2**ADDR_W bytes
- SYNC_STAGES, 2, synchroniser flops on SCL and SDA inputs (min 2)
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- scl  in  1  I2C clock from master (no stretching)
- sda  inout  1  I2C data; driven only low-or-Z via internal enable (open-drain)
- busy  out  1  high from detected START to detected STOP
- done  out  1  one-cycle pulse at STOP ending a transaction that addressed this slave
- addr_hit  out  1  one-cycle pulse when the device address byte matches
- bus_err  out  1  one-cycle pulse on START/STOP detected mid-byte (bit count 1..8)

## Operation
- SCL/SDA pass through SYNC_STAGES flops plus one history flop; scl_rise/scl_fall are edge strobes on the synced signals.
- START = synced SDA falls while synced SCL high; STOP = synced SDA rises while synced SCL high. Both take priority over bit processing in the same cycle.
- Bits are sampled on scl_rise, MSB first. SDA output changes only on the cycle after scl_fall.
- States: IDLE, DEV_ADDR, DEV_ACK, REG_PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
- IDLE -> DEV_ADDR on START.
- DEV_ADDR: after 8 bits, if addr[7:1]==SLAVE_ADDR then addr_hit and go to DEV_ACK, else go to WAIT_STOP with SDA never driven.
- DEV_ACK: drive 0 for the 9th bit. If R/W=0 go to REG_PTR. If R/W=1, fetch mem[ptr] into the shift register and go to RD_DATA.
- REG_PTR: 8 bits; ptr <= byte[ADDR_W-1:0] (upper bits ignored); ACK in PTR_ACK, then WR_DATA.
- WR_DATA: 8 bits; mem[ptr] <= byte on the 8th scl_rise; ptr increments; ACK in WR_ACK, then WR_DATA again.
- RD_DATA: shift out 8 bits; release SDA for RD_ACK; sample master ACK on scl_rise. ACK (0): ptr++, fetch the next byte, go to RD_DATA. NACK (1): WAIT_STOP (normal end, no error).
- ptr wraps modulo 2**ADDR_W (0x7F+1 -> 0x00 for ADDR_W=7). ptr persists across transactions.
- STOP in any state -> IDLE, SDA released, busy low, done pulses if addressed. bus_err also pulses if bit count is 1..8.
- START while busy: see Configuration.

## Timing
- Reset (async): state IDLE, SDA enable 0 (released), busy/done/addr_hit/bus_err 0, ptr 0, mem[i] = i[7:0].
- Pin-to-edge-strobe latency: SYNC_STAGES+1 clk cycles.
- SDA drive/release takes effect 1 clk after the scl_fall strobe, which is ≥ SYNC_STAGES+2 clk after the physical SCL fall. It never changes while synced SCL is high.
- ACK is driven from the 8th-bit scl_fall to the 9th-bit scl_fall; released exactly at the 9th scl_fall (except when entering RD_DATA, which drives the data MSB).
- Memory write is 1 clk after the 8th-bit scl_rise. Read fetch is ready before the next scl_fall.
- Requirement: clk ≥ 16 × SCL frequency.
- Reset asserted mid-transfer: immediate release of SDA. Resume only on a fresh START.

## Configuration
- I2C_SLV_REPSTART_EN defined: START while busy restarts at DEV_ADDR with no bus_err. ptr is kept, so write-pointer-then-repeated-START-read works. done does not pulse on repeated START.
- Undefined: START while busy is an error. bus_err pulses, the state goes to WAIT_STOP, and the slave ignores the bus until STOP. Reads use the pointer left by a prior transaction.

## Test plan
- Write 0xA0, 0x10, 0xDE, 0xAD, STOP -> 4 ACKs low, mem[0x10]=0xDE, mem[0x11]=0xAD, addr_hit once, done once, ptr=0x12.
- (REPSTART_EN) 0xA0, 0x10, Sr, 0xA1, read 2 bytes ACK/NACK, STOP -> SDA returns 0xDE then 0xAD, bus_err 0. Without macro: bus_err pulse at Sr, no data driven.
- Address 0xA2 (0x51) -> SDA stays Z for the whole transfer, addr_hit/done never pulse, busy still tracks START..STOP.
- Wrap: pointer 0x7F, write 0x11, 0x22 -> mem[0x7F]=0x11, mem[0x00]=0x22. Read after reset from ptr 0 returns 0x00, 0x01.
- STOP after 3 bits of a data byte -> bus_err pulse, no memory write, state IDLE.
- Assert rst during the RD_DATA 5th bit -> SDA released within 0 clk, outputs 0, mem restored to identity, next full write transaction succeeds.

Source files
------------

// File: rtl/i2c_slave_mem.sv
// I2C target with a 2**ADDR_W byte register file, register pointer and burst auto-increment; SCL/SDA oversampled on clk.
// Optional macro I2C_SLV_REPSTART_EN: a START while busy restarts the address phase instead of raising bus_err.
`timescale 1ns/1ps
module i2c_slave_mem #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         ADDR_W      = 7,
    parameter int         SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl,
    inout  wire  sda,
    output logic busy,
    output logic done,
    output logic addr_hit,
    output logic bus_err
);
    localparam logic [3:0] IDLE      = 4'd0;
    localparam logic [3:0] DEV_ADDR  = 4'd1;
    localparam logic [3:0] DEV_ACK   = 4'd2;
    localparam logic [3:0] REG_PTR   = 4'd3;
    localparam logic [3:0] PTR_ACK   = 4'd4;
    localparam logic [3:0] WR_DATA   = 4'd5;
    localparam logic [3:0] WR_ACK    = 4'd6;
    localparam logic [3:0] RD_DATA   = 4'd7;
    localparam logic [3:0] RD_ACK    = 4'd8;
    localparam logic [3:0] WAIT_STOP = 4'd9;

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
    logic scl_hist_q, sda_hist_q, scl_s, sda_s;
    logic scl_rise, scl_fall, start_det, stop_det, mid_byte, mem_we;
    logic [3:0] state_q, state_d, bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d, rx_byte;
    logic [2:0] tx_idx;
    logic [ADDR_W-1:0] ptr_q, ptr_d, ptr_inc;
    logic rw_q, rw_d, addressed_q, addressed_d, sda_oe_q, sda_oe_d;
    logic busy_q, busy_d, done_q, done_d, hit_q, hit_d, err_q, err_d;
    logic [7:0] mem_q [2**ADDR_W];

    assign scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl};
    assign sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda};
    assign scl_s      = scl_sync_q[SYNC_STAGES-1];
    assign sda_s      = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise   = scl_s & ~scl_hist_q;
    assign scl_fall   = ~scl_s & scl_hist_q;
    assign start_det  = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
    assign stop_det   = scl_s & scl_hist_q & ~sda_hist_q & sda_s;
    assign rx_byte    = {shift_q[6:0], sda_s};
    assign ptr_inc    = ptr_q + ADDR_W'(1);
    assign tx_idx     = 3'(4'd7 - bit_cnt_q);
    // The SCL-high phase carrying a START/STOP has already been counted, so one
    // counted bit means a clean boundary and 2..8 means the byte was cut short.
    assign mid_byte   = (bit_cnt_q >= 4'd2) && (bit_cnt_q <= 4'd8);

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        ptr_d       = ptr_q;
        rw_d        = rw_q;
        addressed_d = addressed_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        hit_d       = 1'b0;
        err_d       = 1'b0;
        mem_we      = 1'b0;
        if (stop_det) begin
            state_d     = IDLE;
            sda_oe_d    = 1'b0;
            busy_d      = 1'b0;
            bit_cnt_d   = 4'd0;
            done_d      = addressed_q;
            addressed_d = 1'b0;
            err_d       = busy_q && mid_byte;
        end else if (start_det) begin
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b1;
            if (!busy_q) begin
                state_d     = DEV_ADDR;
                addressed_d = 1'b0;
            end else begin
`ifdef I2C_SLV_REPSTART_EN
                state_d = DEV_ADDR;
`else
                state_d = WAIT_STOP;
                err_d   = 1'b1;
`endif
            end
        end else begin
            case (state_q)
                DEV_ADDR, REG_PTR, WR_DATA: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            if (state_q == DEV_ADDR) begin
                                if (rx_byte[7:1] == SLAVE_ADDR) begin
                                    hit_d       = 1'b1;
                                    addressed_d = 1'b1;
                                    rw_d        = rx_byte[0];
                                    state_d     = DEV_ACK;
                                end else begin
                                    state_d   = WAIT_STOP;
                                    bit_cnt_d = 4'd0;
                                end
                            end else if (state_q == REG_PTR) begin
                                ptr_d   = rx_byte[ADDR_W-1:0];
                                state_d = PTR_ACK;
                            end else begin
                                mem_we  = 1'b1;
                                ptr_d   = ptr_inc;
                                state_d = WR_ACK;
                            end
                        end
                    end
                end
                DEV_ACK, PTR_ACK, WR_ACK: begin
                    // bit_cnt 8 = low phase before the ACK clock, 9 = ACK clock seen
                    if (scl_rise) begin
                        bit_cnt_d = 4'd9;
                        if (state_q == DEV_ACK && rw_q) shift_d = mem_q[ptr_q];
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            bit_cnt_d = 4'd0;
                            if (state_q == DEV_ACK && rw_q) begin
                                state_d  = RD_DATA;
                                sda_oe_d = ~shift_q[7];
                            end else begin
                                sda_oe_d = 1'b0;
                                state_d  = (state_q == DEV_ACK) ? REG_PTR : WR_DATA;
                            end
                        end
                    end
                end
                RD_DATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 4'd0;
                            state_d   = RD_ACK;
                        end else begin
                            sda_oe_d = ~shift_q[tx_idx];
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        if (!sda_s) begin
                            ptr_d   = ptr_inc;
                            shift_d = mem_q[ptr_inc];
                            state_d = RD_DATA;
                        end else begin
                            state_d = WAIT_STOP;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync_q  <= '1;
            sda_sync_q  <= '1;
            scl_hist_q  <= 1'b1;
            sda_hist_q  <= 1'b1;
            state_q     <= IDLE;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 8'd0;
            ptr_q       <= '0;
            rw_q        <= 1'b0;
            addressed_q <= 1'b0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            hit_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            scl_sync_q  <= scl_sync_d;
            sda_sync_q  <= sda_sync_d;
            scl_hist_q  <= scl_s;
            sda_hist_q  <= sda_s;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            ptr_q       <= ptr_d;
            rw_q        <= rw_d;
            addressed_q <= addressed_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            hit_q       <= hit_d;
            err_q       <= err_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2**ADDR_W; i++) mem_q[i] <= 8'(i);
        end else if (mem_we) begin
            mem_q[ptr_q] <= rx_byte;
        end
    end

    assign sda      = sda_oe_q ? 1'b0 : 1'bz;
    assign busy     = busy_q;
    assign done     = done_q;
    assign addr_hit = hit_q;
    assign bus_err  = err_q;
endmodule
